// File: rtl/fifo_feed_pkg.sv
// Shared types and default sizing for the operand FIFO bank controller,
// reused by the FIFO bank and the array top.
package fifo_feed_pkg;

   localparam int unsigned FF_DIM    = 8;
   localparam int unsigned FF_DATA_W = 64;
   localparam int unsigned FF_ROW_W  = $clog2(FF_DIM);
   localparam int unsigned FF_CNT_W  = $clog2(2 * FF_DIM);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      FEED,
      DONE
   } feed_state_t;

endpackage

// File: rtl/skew_decode.sv
// Diagonal wavefront decode: FIFO i is enabled for feed cycles i .. i+DIM-1.
module skew_decode #(
   parameter int unsigned DIM   = fifo_feed_pkg::FF_DIM,
   parameter int unsigned CNT_W = fifo_feed_pkg::FF_CNT_W
) (
   input  logic [CNT_W-1:0] feed_cnt_i,
   output logic [DIM-1:0]   mask_o
);

   always_comb begin
      mask_o = '0;
      for (int unsigned i = 0; i < DIM; i++) begin
         mask_o[i] = (32'(feed_cnt_i) >= i) && (32'(feed_cnt_i) <= i + DIM - 1);
      end
   end

endmodule

// File: rtl/fifo_feed_ctrl.sv
// Load/feed sequencer for the systolic-array operand FIFOs. FIFO-side outputs are
// registered one cycle behind the control state so each enable pairs with its data.
module fifo_feed_ctrl #(
   parameter int unsigned DIM    = fifo_feed_pkg::FF_DIM,
   parameter int unsigned DATA_W = fifo_feed_pkg::FF_DATA_W
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic              abort_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [DATA_W-1:0] in_data_i,
   output logic [DIM-1:0]    fifo_en_o,
   output logic [DATA_W-1:0] fifo_d_o,
   output logic              array_valid_o,
   output logic              busy_o,
   output logic              done_o
);

   import fifo_feed_pkg::*;

   localparam int unsigned ROW_W = $clog2(DIM);
   localparam int unsigned CNT_W = $clog2(2 * DIM);
   localparam logic [ROW_W-1:0] RowLast = ROW_W'(DIM - 1);
   localparam logic [CNT_W-1:0] CntLast = CNT_W'(2 * DIM - 2);

   feed_state_t       state_q, state_d;
   logic [ROW_W-1:0]  row_q, row_d;
   logic [ROW_W-1:0]  col_q, col_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DIM-1:0]    en_q, en_d;
   logic [DATA_W-1:0] dat_q, dat_d;
   logic              av_q, av_d;
   logic              done_q, done_d;
   logic              hs;
   logic [DIM-1:0]    skew_mask;

   skew_decode #(
      .DIM   (DIM),
      .CNT_W (CNT_W)
   ) u_skew_decode (
      .feed_cnt_i (cnt_q),
      .mask_o     (skew_mask)
   );

   assign hs = (state_q == LOAD) && in_valid_i;

   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      col_d   = col_q;
      cnt_d   = cnt_q;
      en_d    = '0;
      dat_d   = '0;
      av_d    = 1'b0;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start_i) begin
               state_d = LOAD;
               row_d   = '0;
               col_d   = '0;
            end
         end
         LOAD: begin
            dat_d = dat_q;
            if (hs) begin
               en_d  = DIM'(1) << row_q;
               dat_d = in_data_i;
               col_d = col_q + 1'b1;
               if (col_q == RowLast) begin
                  col_d = '0;
                  row_d = row_q + 1'b1;
                  if (row_q == RowLast) begin
                     state_d = FEED;
                     row_d   = '0;
                     cnt_d   = '0;
                  end
               end
            end
         end
         FEED: begin
            en_d  = skew_mask;
            av_d  = 1'b1;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CntLast) begin
               state_d = DONE;
               cnt_d   = '0;
            end
         end
         DONE: begin
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // abort overrides everything, including a start seen in the same cycle
      if (abort_i) begin
         state_d = IDLE;
         row_d   = '0;
         col_d   = '0;
         cnt_d   = '0;
         en_d    = '0;
         dat_d   = '0;
         av_d    = 1'b0;
         done_d  = 1'b0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         row_q   <= '0;
         col_q   <= '0;
         cnt_q   <= '0;
         en_q    <= '0;
         dat_q   <= '0;
         av_q    <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         col_q   <= col_d;
         cnt_q   <= cnt_d;
         en_q    <= en_d;
         dat_q   <= dat_d;
         av_q    <= av_d;
         done_q  <= done_d;
      end
   end

   assign in_ready_o    = (state_q == LOAD);
   assign fifo_en_o     = en_q;
   assign fifo_d_o      = dat_q;
   assign array_valid_o = av_q;
   assign done_o        = done_q;
   // Stay busy until the delayed output stage has drained, through the done pulse.
   assign busy_o        = (state_q != IDLE) || av_q || done_q || (|en_q);

endmodule
